// File: rtl/execute_pkg.sv
// Shared definitions for the execute stage: ALU op codes, memory access
// size codes and the mul/div sequencer state encoding.
package execute_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_BEQ  = 4'd10;
    localparam logic [3:0] ALU_BNE  = 4'd11;
    localparam logic [3:0] ALU_MUL  = 4'd12;
    localparam logic [3:0] ALU_DIVU = 4'd13;
    localparam logic [3:0] ALU_REMU = 4'd14;

    // Memory access size; zero means no access so a bubble is all-zero.
    localparam logic [1:0] MEM_NONE = 2'd0;
    localparam logic [1:0] MEM_WORD = 2'd1;
    localparam logic [1:0] MEM_HALF = 2'd2;
    localparam logic [1:0] MEM_BYTE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/execute_muldiv.sv
// Iterative 32-step unit: shift-add multiply (low word) and restoring
// unsigned divide / remainder. A zero divisor naturally yields an all-ones
// quotient and the dividend as remainder.
module execute_muldiv
    import execute_pkg::*;
#(
    parameter int MULDIV_ITER = 32
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    md_state_t   state, state_nxt;
    logic [4:0]  cnt;
    logic [3:0]  op_q;
    logic [31:0] acc_q;   // product accumulator / partial remainder
    logic [31:0] q_q;     // multiplier / dividend shifting into quotient
    logic [31:0] d_q;     // multiplicand / divisor
    logic        last;
    logic [32:0] rem_sh;
    logic [31:0] rem_sub;
    logic        rem_ge;

    assign last    = (cnt == 5'(MULDIV_ITER - 1));
    assign rem_sh  = {acc_q, q_q[31]};
    assign rem_sub = rem_sh[31:0] - d_q;
    assign rem_ge  = (rem_sh >= {1'b0, d_q});

    // State register
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; abort always returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_i && !abort_i) state_nxt = ST_BUSY;
            ST_BUSY: if (abort_i) state_nxt = ST_IDLE;
                     else if (last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand load on issue, one iteration per BUSY cycle
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            cnt   <= '0;
            op_q  <= ALU_ADD;
            acc_q <= '0;
            q_q   <= '0;
            d_q   <= '0;
        end else if (state == ST_IDLE && start_i && !abort_i) begin
            cnt   <= '0;
            op_q  <= op_i;
            acc_q <= '0;
            if (op_i == ALU_MUL) begin
                q_q <= b_i;
                d_q <= a_i;
            end else begin
                q_q <= a_i;
                d_q <= b_i;
            end
        end else if (state == ST_BUSY) begin
            cnt <= cnt + 5'd1;
            if (op_q == ALU_MUL) begin
                if (q_q[0]) acc_q <= acc_q + d_q;
                d_q <= d_q << 1;
                q_q <= q_q >> 1;
            end else if (rem_ge) begin
                acc_q <= rem_sub;
                q_q   <= {q_q[30:0], 1'b1};
            end else begin
                acc_q <= rem_sh[31:0];
                q_q   <= {q_q[30:0], 1'b0};
            end
        end
    end

    assign busy_o   = (state == ST_BUSY);
    assign done_o   = (state == ST_DONE);
    assign result_o = (op_q == ALU_DIVU) ? q_q : acc_q;

endmodule

// File: rtl/execute.sv
// Execute stage: single-cycle ALU and branch resolution registered into
// EXMEM, plus a stalling iterative mul/div path.
module execute
    import execute_pkg::*;
#(
    parameter int BRANCH_SHIFT = 2,
    parameter int MULDIV_ITER  = 32
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic [31:0] IDEX_pc_i,
    input  logic [31:0] IDEX_a_i,
    input  logic [31:0] IDEX_b_i,
    input  logic [31:0] IDEX_imm_i,
    input  logic [4:0]  IDEX_rt_i,
    input  logic [4:0]  IDEX_rd_i,
    input  logic [3:0]  IDEX_ctrl_alu_op_i,
    input  logic        IDEX_ctrl_alu_src_i,
    input  logic        IDEX_ctrl_reg_dst_i,
    input  logic        IDEX_ctrl_branch_i,
    input  logic        IDEX_ctrl_reg_write_i,
    input  logic        IDEX_ctrl_mem_to_reg_i,
    input  logic [1:0]  IDEX_ctrl_mem_read_i,
    input  logic [1:0]  IDEX_ctrl_mem_write_i,
    input  logic        flush_i,
    output logic [31:0] EXMEM_pc_branched_o,
    output logic [31:0] EXMEM_alu_o,
    output logic [31:0] EXMEM_b_o,
    output logic        EXMEM_alu_do_branch_o,
    output logic [4:0]  EXMEM_reg_write_address_o,
    output logic        EXMEM_ctrl_branch_o,
    output logic        EXMEM_ctrl_reg_write_o,
    output logic        EXMEM_ctrl_mem_to_reg_o,
    output logic [1:0]  EXMEM_ctrl_mem_read_o,
    output logic [1:0]  EXMEM_ctrl_mem_write_o,
    output logic        EX_stall_o
);

    logic        [31:0] op2;
    logic signed [31:0] a_s, op2_s;
    logic        [4:0]  shamt;
    logic        [31:0] alu_res;
    logic               do_branch;
    logic        [31:0] pc_branched;
    logic        [4:0]  dest;
    logic               md_op, md_busy, md_done, md_issue;
    logic        [31:0] md_result;

    assign op2         = IDEX_ctrl_alu_src_i ? IDEX_imm_i : IDEX_b_i;
    assign a_s         = $signed(IDEX_a_i);
    assign op2_s       = $signed(op2);
    assign shamt       = op2[4:0];
    assign dest        = IDEX_ctrl_reg_dst_i ? IDEX_rd_i : IDEX_rt_i;
    assign pc_branched = IDEX_pc_i + (IDEX_imm_i << BRANCH_SHIFT);
    assign md_op       = is_muldiv(IDEX_ctrl_alu_op_i);
    assign md_issue    = md_op && !md_busy && !md_done && !flush_i;
    assign EX_stall_o  = n_rst_i && (md_issue || md_busy);

    // Single-cycle ALU and branch condition
    always_comb begin
        alu_res   = '0;
        do_branch = 1'b0;
        case (IDEX_ctrl_alu_op_i)
            ALU_ADD: alu_res = IDEX_a_i + op2;
            ALU_SUB: alu_res = IDEX_a_i - op2;
            ALU_AND: alu_res = IDEX_a_i & op2;
            ALU_OR:  alu_res = IDEX_a_i | op2;
            ALU_XOR: alu_res = IDEX_a_i ^ op2;
            ALU_NOR: alu_res = ~(IDEX_a_i | op2);
            ALU_SLT: alu_res = {31'd0, (a_s < op2_s)};
            ALU_SLL: alu_res = IDEX_a_i << shamt;
            ALU_SRL: alu_res = IDEX_a_i >> shamt;
            ALU_SRA: alu_res = a_s >>> shamt;
            ALU_BEQ: begin
                alu_res   = IDEX_a_i - op2;
                do_branch = (IDEX_a_i == op2);
            end
            ALU_BNE: begin
                alu_res   = IDEX_a_i - op2;
                do_branch = (IDEX_a_i != op2);
            end
            default: alu_res = '0;
        endcase
    end

    execute_muldiv #(
        .MULDIV_ITER(MULDIV_ITER)
    ) u_muldiv (
        .clk_i   (clk_i),
        .n_rst_i (n_rst_i),
        .start_i (md_op),
        .abort_i (flush_i),
        .op_i    (IDEX_ctrl_alu_op_i),
        .a_i     (IDEX_a_i),
        .b_i     (op2),
        .busy_o  (md_busy),
        .done_o  (md_done),
        .result_o(md_result)
    );

    // EXMEM register: bubble on flush or stall, mul/div result in DONE
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            EXMEM_pc_branched_o       <= '0;
            EXMEM_alu_o               <= '0;
            EXMEM_b_o                 <= '0;
            EXMEM_alu_do_branch_o     <= 1'b0;
            EXMEM_reg_write_address_o <= '0;
            EXMEM_ctrl_branch_o       <= 1'b0;
            EXMEM_ctrl_reg_write_o    <= 1'b0;
            EXMEM_ctrl_mem_to_reg_o   <= 1'b0;
            EXMEM_ctrl_mem_read_o     <= MEM_NONE;
            EXMEM_ctrl_mem_write_o    <= MEM_NONE;
        end else if (flush_i || md_issue || md_busy) begin
            EXMEM_alu_do_branch_o     <= 1'b0;
            EXMEM_ctrl_branch_o       <= 1'b0;
            EXMEM_ctrl_reg_write_o    <= 1'b0;
            EXMEM_ctrl_mem_to_reg_o   <= 1'b0;
            EXMEM_ctrl_mem_read_o     <= MEM_NONE;
            EXMEM_ctrl_mem_write_o    <= MEM_NONE;
        end else begin
            EXMEM_pc_branched_o       <= pc_branched;
            EXMEM_alu_o               <= md_done ? md_result : alu_res;
            EXMEM_b_o                 <= IDEX_b_i;
            EXMEM_alu_do_branch_o     <= md_done ? 1'b0 : do_branch;
            EXMEM_reg_write_address_o <= dest;
            EXMEM_ctrl_branch_o       <= IDEX_ctrl_branch_i;
            EXMEM_ctrl_reg_write_o    <= IDEX_ctrl_reg_write_i;
            EXMEM_ctrl_mem_to_reg_o   <= IDEX_ctrl_mem_to_reg_i;
            EXMEM_ctrl_mem_read_o     <= IDEX_ctrl_mem_read_i;
            EXMEM_ctrl_mem_write_o    <= IDEX_ctrl_mem_write_i;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for the execute stage: issued instructions push their
// expected EXMEM image; a negedge monitor pops and compares on each result.
module tb_execute;
    import execute_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst_i;
    logic [31:0] IDEX_pc_i, IDEX_a_i, IDEX_b_i, IDEX_imm_i;
    logic [4:0]  IDEX_rt_i, IDEX_rd_i;
    logic [3:0]  IDEX_ctrl_alu_op_i;
    logic        IDEX_ctrl_alu_src_i, IDEX_ctrl_reg_dst_i, IDEX_ctrl_branch_i;
    logic        IDEX_ctrl_reg_write_i, IDEX_ctrl_mem_to_reg_i;
    logic [1:0]  IDEX_ctrl_mem_read_i, IDEX_ctrl_mem_write_i;
    logic        flush_i;
    logic [31:0] EXMEM_pc_branched_o, EXMEM_alu_o, EXMEM_b_o;
    logic        EXMEM_alu_do_branch_o;
    logic [4:0]  EXMEM_reg_write_address_o;
    logic        EXMEM_ctrl_branch_o, EXMEM_ctrl_reg_write_o, EXMEM_ctrl_mem_to_reg_o;
    logic [1:0]  EXMEM_ctrl_mem_read_o, EXMEM_ctrl_mem_write_o;
    logic        EX_stall_o;

    typedef struct packed {
        logic [31:0] alu;
        logic [4:0]  addr;
        logic        br;
        logic [31:0] pcb;
        logic [31:0] b;
        logic        bctl;
        logic        m2r;
        logic [1:0]  mr;
        logic [1:0]  mw;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    execute #(.BRANCH_SHIFT(2), .MULDIV_ITER(32)) dut (
        .clk_i(clk), .n_rst_i(n_rst_i),
        .IDEX_pc_i(IDEX_pc_i), .IDEX_a_i(IDEX_a_i), .IDEX_b_i(IDEX_b_i),
        .IDEX_imm_i(IDEX_imm_i), .IDEX_rt_i(IDEX_rt_i), .IDEX_rd_i(IDEX_rd_i),
        .IDEX_ctrl_alu_op_i(IDEX_ctrl_alu_op_i),
        .IDEX_ctrl_alu_src_i(IDEX_ctrl_alu_src_i),
        .IDEX_ctrl_reg_dst_i(IDEX_ctrl_reg_dst_i),
        .IDEX_ctrl_branch_i(IDEX_ctrl_branch_i),
        .IDEX_ctrl_reg_write_i(IDEX_ctrl_reg_write_i),
        .IDEX_ctrl_mem_to_reg_i(IDEX_ctrl_mem_to_reg_i),
        .IDEX_ctrl_mem_read_i(IDEX_ctrl_mem_read_i),
        .IDEX_ctrl_mem_write_i(IDEX_ctrl_mem_write_i),
        .flush_i(flush_i),
        .EXMEM_pc_branched_o(EXMEM_pc_branched_o), .EXMEM_alu_o(EXMEM_alu_o),
        .EXMEM_b_o(EXMEM_b_o), .EXMEM_alu_do_branch_o(EXMEM_alu_do_branch_o),
        .EXMEM_reg_write_address_o(EXMEM_reg_write_address_o),
        .EXMEM_ctrl_branch_o(EXMEM_ctrl_branch_o),
        .EXMEM_ctrl_reg_write_o(EXMEM_ctrl_reg_write_o),
        .EXMEM_ctrl_mem_to_reg_o(EXMEM_ctrl_mem_to_reg_o),
        .EXMEM_ctrl_mem_read_o(EXMEM_ctrl_mem_read_o),
        .EXMEM_ctrl_mem_write_o(EXMEM_ctrl_mem_write_o),
        .EX_stall_o(EX_stall_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic nop();
        IDEX_ctrl_alu_op_i     = ALU_ADD;
        IDEX_a_i               = '0;
        IDEX_b_i               = '0;
        IDEX_imm_i             = '0;
        IDEX_pc_i              = '0;
        IDEX_rt_i              = '0;
        IDEX_rd_i              = '0;
        IDEX_ctrl_alu_src_i    = 1'b0;
        IDEX_ctrl_reg_dst_i    = 1'b0;
        IDEX_ctrl_branch_i     = 1'b0;
        IDEX_ctrl_reg_write_i  = 1'b0;
        IDEX_ctrl_mem_to_reg_i = 1'b0;
        IDEX_ctrl_mem_read_i   = MEM_NONE;
        IDEX_ctrl_mem_write_i  = MEM_NONE;
    endtask

    // Called just after a rising edge; returns just after the edge that
    // captured the instruction's result.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic src, input logic dst, input logic bctl, input logic m2r,
                         input logic [1:0] mr, input logic [1:0] mw,
                         input logic [31:0] exp_alu, input logic [4:0] exp_addr,
                         input logic exp_br, input logic [31:0] exp_pcb, input int exp_stall);
        exp_t e;
        int   n;
        int   bad;
        IDEX_ctrl_alu_op_i     = op;
        IDEX_a_i               = a;
        IDEX_b_i               = b;
        IDEX_imm_i             = imm;
        IDEX_pc_i              = pc;
        IDEX_rt_i              = rt;
        IDEX_rd_i              = rd;
        IDEX_ctrl_alu_src_i    = src;
        IDEX_ctrl_reg_dst_i    = dst;
        IDEX_ctrl_branch_i     = bctl;
        IDEX_ctrl_reg_write_i  = 1'b1;
        IDEX_ctrl_mem_to_reg_i = m2r;
        IDEX_ctrl_mem_read_i   = mr;
        IDEX_ctrl_mem_write_i  = mw;
        e = '{alu: exp_alu, addr: exp_addr, br: exp_br, pcb: exp_pcb, b: b,
              bctl: bctl, m2r: m2r, mr: mr, mw: mw};
        q.push_back(e);
        n = 0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!EX_stall_o) break;
            if (n > 0 && (EXMEM_ctrl_reg_write_o || EXMEM_ctrl_branch_o || EXMEM_ctrl_mem_to_reg_o
                          || EXMEM_ctrl_mem_read_o != 2'd0 || EXMEM_ctrl_mem_write_o != 2'd0
                          || EXMEM_alu_do_branch_o))
                bad++;
            n++;
        end
        check("stall_cycles", n, exp_stall);
        if (exp_stall > 0) check("bubbles_during_stall", bad, 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (n_rst_i && EXMEM_ctrl_reg_write_o) begin
            exp_t e, g;
            g = '{alu: EXMEM_alu_o, addr: EXMEM_reg_write_address_o, br: EXMEM_alu_do_branch_o,
                  pcb: EXMEM_pc_branched_o, b: EXMEM_b_o, bctl: EXMEM_ctrl_branch_o,
                  m2r: EXMEM_ctrl_mem_to_reg_o, mr: EXMEM_ctrl_mem_read_o,
                  mw: EXMEM_ctrl_mem_write_o};
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: alu=0x%08h addr=%0d, expected no result", g.alu, g.addr);
            end else begin
                e = q.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL exmem: got alu=%h addr=%0d br=%b pcb=%h b=%h ctl=%b%b%h%h, expected alu=%h addr=%0d br=%b pcb=%h b=%h ctl=%b%b%h%h",
                             g.alu, g.addr, g.br, g.pcb, g.b, g.bctl, g.m2r, g.mr, g.mw,
                             e.alu, e.addr, e.br, e.pcb, e.b, e.bctl, e.m2r, e.mr, e.mw);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        nop();
        flush_i = 1'b0;
        n_rst_i = 1'b0;
        IDEX_ctrl_alu_op_i = ALU_MUL;
        #12;
        check("rst_stall", {31'd0, EX_stall_o}, 32'd0);
        check("rst_alu", EXMEM_alu_o, 32'd0);
        check("rst_ctrl", {27'd0, EXMEM_ctrl_reg_write_o, EXMEM_ctrl_mem_read_o, EXMEM_ctrl_mem_write_o}, 32'd0);
        nop();
        @(negedge clk);
        n_rst_i = 1'b1;
        @(posedge clk);
        #1;

        // Single-cycle ops, back to back
        issue(ALU_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1,
              MEM_NONE, MEM_WORD, 32'd12, 5'd3, 1'b0, 32'd0, 0);
        issue(ALU_SUB, 32'd5, 32'd7, 32'd0, 32'd0, 5'd9, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0,
              MEM_BYTE, MEM_NONE, 32'hFFFF_FFFE, 5'd9, 1'b0, 32'd0, 0);
        issue(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'd0, 5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0,
              MEM_NONE, MEM_NONE, 32'h0000_F000, 5'd5, 1'b0, 32'd0, 0);
        issue(ALU_OR, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'd0, 5'd1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0,
              MEM_HALF, MEM_NONE, 32'h0000_FFF0, 5'd6, 1'b0, 32'd0, 0);
        issue(ALU_XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'd0, 5'd1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0,
              MEM_NONE, MEM_HALF, 32'h0000_0FF0, 5'd7, 1'b0, 32'd0, 0);
        issue(ALU_NOR, 32'd0, 32'hFFFF_0000, 32'd0, 32'd0, 5'd1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0,
              MEM_NONE, MEM_NONE, 32'h0000_FFFF, 5'd8, 1'b0, 32'd0, 0);
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd1, 5'd10, 1'b0, 1'b1, 1'b0, 1'b0,
              MEM_NONE, MEM_NONE, 32'd1, 5'd10, 1'b0, 32'd0, 0);
        issue(ALU_SLL, 32'd1, 32'd0, 32'd4, 32'd0, 5'd1, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0,
              MEM_NONE, MEM_NONE, 32'd16, 5'd11, 1'b0, 32'd16, 0);
        issue(ALU_SRL, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd1, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0,
              MEM_NONE, MEM_NONE, 32'h0800_0000, 5'd12, 1'b0, 32'd0, 0);
        issue(ALU_SRA, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd1, 5'd13, 1'b0, 1'b1, 1'b0, 1'b0,
              MEM_NONE, MEM_NONE, 32'hF800_0000, 5'd13, 1'b0, 32'd0, 0);
        issue(ALU_BEQ, 32'd3, 32'd3, 32'd4, 32'h100, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
              MEM_NONE, MEM_NONE, 32'd0, 5'd1, 1'b1, 32'h110, 0);
        issue(ALU_BNE, 32'd3, 32'd3, 32'hFFFF_FFFF, 32'h100, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
              MEM_NONE, MEM_NONE, 32'd0, 5'd2, 1'b0, 32'h0FC, 0);

        // Multi-cycle ops; DIVU then REMU issued back to back
        issue(ALU_MUL, 32'h0001_0000, 32'h0001_0001, 32'd0, 32'd0, 5'd1, 5'd14, 1'b0, 1'b1, 1'b0, 1'b0,
              MEM_NONE, MEM_NONE, 32'h0001_0000, 5'd14, 1'b0, 32'd0, 33);
        issue(ALU_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 5'd1, 5'd15, 1'b0, 1'b1, 1'b0, 1'b0,
              MEM_NONE, MEM_NONE, 32'd14, 5'd15, 1'b0, 32'd0, 33);
        issue(ALU_REMU, 32'd100, 32'd7, 32'd0, 32'd0, 5'd1, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0,
              MEM_NONE, MEM_NONE, 32'd2, 5'd16, 1'b0, 32'd0, 33);
        issue(ALU_DIVU, 32'd9, 32'd0, 32'd0, 32'd0, 5'd1, 5'd17, 1'b0, 1'b1, 1'b0, 1'b0,
              MEM_NONE, MEM_NONE, 32'hFFFF_FFFF, 5'd17, 1'b0, 32'd0, 33);
        issue(ALU_REMU, 32'd9, 32'd0, 32'd0, 32'd0, 5'd1, 5'd18, 1'b0, 1'b1, 1'b0, 1'b0,
              MEM_NONE, MEM_NONE, 32'd9, 5'd18, 1'b0, 32'd0, 33);
        nop();
        @(posedge clk);
        #1;

        // Flush during BUSY iteration 10: no result may ever appear
        IDEX_ctrl_alu_op_i    = ALU_MUL;
        IDEX_a_i              = 32'd3;
        IDEX_b_i              = 32'd5;
        IDEX_rd_i             = 5'd20;
        IDEX_ctrl_reg_dst_i   = 1'b1;
        IDEX_ctrl_reg_write_i = 1'b1;
        repeat (11) @(negedge clk);
        check("stall_before_flush", {31'd0, EX_stall_o}, 32'd1);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        nop();
        @(negedge clk);
        check("stall_after_flush", {31'd0, EX_stall_o}, 32'd0);
        check("flush_bubble", {30'd0, EXMEM_ctrl_reg_write_o, EXMEM_alu_do_branch_o}, 32'd0);
        repeat (40) @(negedge clk);

        // Reset in the middle of a divide
        @(posedge clk);
        #1;
        IDEX_ctrl_alu_op_i    = ALU_DIVU;
        IDEX_a_i              = 32'd50;
        IDEX_b_i              = 32'd5;
        IDEX_rd_i             = 5'd21;
        IDEX_ctrl_reg_dst_i   = 1'b1;
        IDEX_ctrl_reg_write_i = 1'b1;
        repeat (6) @(negedge clk);
        n_rst_i = 1'b0;
        #1;
        check("midrst_stall", {31'd0, EX_stall_o}, 32'd0);
        check("midrst_alu", EXMEM_alu_o, 32'd0);
        check("midrst_pcb", EXMEM_pc_branched_o, 32'd0);
        check("midrst_misc", {EXMEM_b_o[23:0], EXMEM_reg_write_address_o, EXMEM_alu_do_branch_o,
                              EXMEM_ctrl_branch_o, EXMEM_ctrl_mem_to_reg_o}, 32'd0);
        nop();
        @(negedge clk);
        n_rst_i = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_stall", {31'd0, EX_stall_o}, 32'd0);
        @(posedge clk);
        #1;
        issue(ALU_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 5'd22, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
              MEM_NONE, MEM_NONE, 32'd3, 5'd22, 1'b0, 32'd0, 0);
        nop();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
